regfile_write_scheduler: RTL and testbench

// - Shares the single write port of the 4x8 CPU register file between two write-back requesters (0 = ALU, 1 = load unit).
// - Tracks destination registers claimed at issue in a busy scoreboard so decode can stall on RAW/WAW hazards.
// - Sits between the execute/load write-back stages and the register file write port.
// - Registers the file's write_enable/write_address/write_data inputs so they are glitch-free.

---
 rtl/cpu_rf_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 30 +++
 rtl/regfile_write_scheduler.sv | 82 ++++++++
 tb/tb_regfile_write_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_rf_pkg.sv
// Shared constants for the register-file write scheduler.
// Register file geometry and write-back requester indices.
package cpu_rf_pkg;

  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 8;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  function automatic logic [NUM_REGS-1:0] reg_onehot(
    input logic [ADDR_W-1:0] a
  );
    reg_onehot = NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, at most one grant per cycle.
// Ports: clk, reset (sync, high), valid[1:0] in, grant[1:0] out.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (valid == 2'b11)
        grant = ptr ? 2'b10 : 2'b01;
      else
        grant = valid;
    end
  end

  // After a grant, favour the requester that was not served.
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= 1'b0;
    else if (|grant)
      ptr <= grant[0];
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between ALU and load write-back
// and keeps a busy scoreboard. Ports: clk, reset, wb_*, claim_*, busy_mask, rf_*.
module regfile_write_scheduler
  import cpu_rf_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          wb_valid,
  output logic [1:0]          wb_ready,
  input  logic [ADDR_W-1:0]   wb_addr0,
  input  logic [ADDR_W-1:0]   wb_addr1,
  input  logic [DATA_W-1:0]   wb_data0,
  input  logic [DATA_W-1:0]   wb_data1,
  input  logic                claim_valid,
  input  logic [ADDR_W-1:0]   claim_addr,
  output logic                claim_ready,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                rf_write_enable,
  output logic [ADDR_W-1:0]   rf_write_address,
  output logic [DATA_W-1:0]   rf_write_data
);

  logic [1:0]          xfer;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid (wb_valid),
    .grant (wb_ready)
  );

  // wb_ready is already zero during reset, so reset-cycle
  // transfers vanish here.
  assign xfer = wb_valid & wb_ready;

  always_comb begin
    sel_addr = wb_addr0;
    sel_data = wb_data0;
    if (xfer[REQ_LOAD]) begin
      sel_addr = wb_addr1;
      sel_data = wb_data1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable  <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
    end else begin
      rf_write_enable <= |xfer;
      if (|xfer) begin
        rf_write_address <= sel_addr;
        rf_write_data    <= sel_data;
      end
    end
  end

  assign claim_ready = claim_valid & ~busy_mask[claim_addr] & ~reset;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (claim_ready)
      set_mask = reg_onehot(claim_addr);
    if (|xfer)
      clr_mask = reg_onehot(sel_addr);
  end

  // Set beats clear on the same register.
  always_ff @(posedge clk) begin
    if (reset)
      busy_mask <= '0;
    else
      busy_mask <= (busy_mask & ~clr_mask) | set_mask;
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler.
// Hand-computed expectations for arbitration, write port and scoreboard.
module tb_regfile_write_scheduler;
  import cpu_rf_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          wb_valid;
  logic [1:0]          wb_ready;
  logic [ADDR_W-1:0]   wb_addr0, wb_addr1;
  logic [DATA_W-1:0]   wb_data0, wb_data1;
  logic                claim_valid;
  logic [ADDR_W-1:0]   claim_addr;
  logic                claim_ready;
  logic [NUM_REGS-1:0] busy_mask;
  logic                rf_write_enable;
  logic [ADDR_W-1:0]   rf_write_address;
  logic [DATA_W-1:0]   rf_write_data;

  int n_chk = 0;
  int n_ok  = 0;

  regfile_write_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_addr0         (wb_addr0),
    .wb_addr1         (wb_addr1),
    .wb_data0         (wb_data0),
    .wb_data1         (wb_data1),
    .claim_valid      (claim_valid),
    .claim_addr       (claim_addr),
    .claim_ready      (claim_ready),
    .busy_mask        (busy_mask),
    .rf_write_enable  (rf_write_enable),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_ok++;
    else
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    chk({tag, ".we"}, 32'(rf_write_enable), 32'd1);
    chk({tag, ".addr"}, 32'(rf_write_address), 32'(a));
    chk({tag, ".data"}, 32'(rf_write_data), 32'(d));
  endtask

  initial begin
    reset = 1'b1;
    wb_valid = 2'b11;
    wb_addr0 = '0; wb_addr1 = '0;
    wb_data0 = 8'h99; wb_data1 = 8'h88;
    claim_valid = 1'b1;
    claim_addr = 2'd0;
    tick();
    settle();
    chk("rst.ready", 32'(wb_ready), 32'h0);
    chk("rst.claim", 32'(claim_ready), 32'h0);
    tick();
    wb_valid = 2'b00;
    claim_valid = 1'b0;
    reset = 1'b0;
    settle();
    chk("rst.we", 32'(rf_write_enable), 32'h0);
    chk("rst.addr", 32'(rf_write_address), 32'h0);
    chk("rst.data", 32'(rf_write_data), 32'h0);
    chk("rst.busy", 32'(busy_mask), 32'h0);

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle.we", 32'(rf_write_enable), 32'h0);
      chk("idle.busy", 32'(busy_mask), 32'h0);
      chk("idle.ready", 32'(wb_ready), 32'h0);
    end

    // Single requester
    wb_valid = 2'b01;
    wb_addr0 = 2'd2;
    wb_data0 = 8'hA5;
    settle();
    chk("single.ready", 32'(wb_ready), 32'h1);
    tick();
    wb_valid = 2'b00;
    chk_wr("single.wr", 2'd2, 8'hA5);
    tick();
    chk("single.we0", 32'(rf_write_enable), 32'h0);
    chk("single.hold_a", 32'(rf_write_address), 32'h2);
    chk("single.hold_d", 32'(rf_write_data), 32'hA5);

    // Contention right after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wb_valid = 2'b11;
    wb_addr0 = 2'd0;
    wb_addr1 = 2'd1;
    for (int i = 0; i < 4; i++) begin
      wb_data0 = 8'(8'h10 + i);
      wb_data1 = 8'(8'h20 + i);
      settle();
      chk("cont.ready", 32'(wb_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      if (i % 2 == 0)
        chk_wr("cont.alu", 2'd0, 8'(8'h10 + i));
      else
        chk_wr("cont.load", 2'd1, 8'(8'h20 + i));
    end
    wb_valid = 2'b00;
    tick();
    chk("cont.idle", 32'(rf_write_enable), 32'h0);

    // Scoreboard: claim r3, stall, release, reclaim
    claim_valid = 1'b1;
    claim_addr = 2'd3;
    settle();
    chk("sb.claim1", 32'(claim_ready), 32'h1);
    tick();
    chk("sb.busy3", 32'(busy_mask), 32'h8);
    settle();
    chk("sb.stall", 32'(claim_ready), 32'h0);
    claim_valid = 1'b0;
    wb_valid = 2'b01;
    wb_addr0 = 2'd3;
    wb_data0 = 8'h33;
    tick();
    wb_valid = 2'b00;
    chk("sb.clear", 32'(busy_mask), 32'h0);
    chk_wr("sb.wr3", 2'd3, 8'h33);
    claim_valid = 1'b1;
    settle();
    chk("sb.claim2", 32'(claim_ready), 32'h1);
    tick();
    claim_valid = 1'b0;
    chk("sb.busy3b", 32'(busy_mask), 32'h8);
    wb_valid = 2'b01;
    wb_data0 = 8'h34;
    tick();
    wb_valid = 2'b00;
    chk("sb.clear2", 32'(busy_mask), 32'h0);

    // Same-cycle claim and write-back on r1: set wins
    claim_valid = 1'b1;
    claim_addr = 2'd1;
    wb_valid = 2'b10;
    wb_addr1 = 2'd1;
    wb_data1 = 8'h5A;
    settle();
    chk("same.ready", 32'(wb_ready), 32'h2);
    tick();
    chk("same.busy", 32'(busy_mask), 32'h2);
    chk_wr("same.wr", 2'd1, 8'h5A);

    // Claim r2 while writing back r1: independent bits
    claim_addr = 2'd2;
    wb_valid = 2'b01;
    wb_addr0 = 2'd1;
    wb_data0 = 8'h77;
    tick();
    claim_valid = 1'b0;
    wb_valid = 2'b00;
    chk("indep.busy", 32'(busy_mask), 32'h4);
    chk_wr("indep.wr", 2'd1, 8'h77);

    // Write-back to non-busy r0 leaves busy unchanged
    wb_valid = 2'b01;
    wb_addr0 = 2'd0;
    wb_data0 = 8'h42;
    tick();
    wb_valid = 2'b00;
    chk("nb.busy", 32'(busy_mask), 32'h4);
    chk_wr("nb.wr", 2'd0, 8'h42);

    // Both requesters to r0; pointer now favours LOAD
    wb_valid = 2'b11;
    wb_addr0 = 2'd0; wb_data0 = 8'hAA;
    wb_addr1 = 2'd0; wb_data1 = 8'hBB;
    settle();
    chk("dup.g1", 32'(wb_ready), 32'h2);
    tick();
    wb_valid = 2'b01;
    chk_wr("dup.wr1", 2'd0, 8'hBB);
    settle();
    chk("dup.g2", 32'(wb_ready), 32'h1);
    tick();
    wb_valid = 2'b00;
    chk_wr("dup.wr2", 2'd0, 8'hAA);

    // Reset during a transfer
    reset = 1'b1;
    wb_valid = 2'b11;
    wb_addr0 = 2'd2; wb_data0 = 8'hC3;
    wb_addr1 = 2'd3; wb_data1 = 8'hD4;
    settle();
    chk("mid.ready", 32'(wb_ready), 32'h0);
    tick();
    reset = 1'b0;
    chk("mid.we", 32'(rf_write_enable), 32'h0);
    chk("mid.busy", 32'(busy_mask), 32'h0);
    settle();
    chk("mid.first", 32'(wb_ready), 32'h1);
    tick();
    wb_valid = 2'b00;
    chk_wr("mid.wr", 2'd2, 8'hC3);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
